// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge: byte valid/ready streams <-> polled UART registers over a Wishbone master, one cycle in flight.
// Latency: POLL_DIV idle cycles + 2-cycle status read + 2-cycle data access; backpressure by holding tx_ready low / rx_valid high.
// Optional ack timeout with sticky err is built when UART_BRIDGE_TIMEOUT_EN is defined.
module uart_stream_bridge #(
  parameter logic [31:0] STATUS_ADDR    = 32'h3000_0008,
  parameter logic [31:0] TXDATA_ADDR    = 32'h3000_0004,
  parameter logic [31:0] RXDATA_ADDR    = 32'h3000_0000,
  parameter int unsigned TX_FULL_BIT    = 0,
  parameter int unsigned RX_EMPTY_BIT   = 1,
  parameter int unsigned POLL_DIV       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        err,
  input  logic        err_clr
);

  localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_STAT, S_WTX, S_RRX} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [7:0]    rx_dat_q, rx_dat_d;
  logic          rx_vld_q, rx_vld_d;
  logic          ack;
  logic          abort;

  // Acks are only meaningful while a cycle is open.
  assign ack      = wbm_ack_i && (state_q != S_IDLE);
  assign tx_ready = !hold_vld_q;
  assign rx_valid = rx_vld_q;
  assign rx_data  = rx_dat_q;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  assign abort = (state_q != S_IDLE) && !wbm_ack_i && (wait_q == WAIT_LAST);
  assign err   = err_q;

  always_comb begin
    wait_d = (state_q == S_IDLE || state_d != state_q) ? 8'd0 : wait_q + 8'd1;
    err_d  = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end else if (abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, wbm_dat_i};
`else
  assign abort = 1'b0;
  assign err   = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, err_clr, wbm_dat_i, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // TX wins over RX; RX eligibility looks at the registered rx_valid only.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (poll_q == POLL_LAST) state_d = S_STAT;
      end
      S_STAT: begin
        if (ack) begin
          if (hold_vld_q && !wbm_dat_i[TX_FULL_BIT]) begin
            state_d = S_WTX;
          end else if (!wbm_dat_i[RX_EMPTY_BIT] && !rx_vld_q) begin
            state_d = S_RRX;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WTX, S_RRX: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = 32'h0;
    wbm_dat_o = 32'h0;
    case (state_q)
      S_STAT: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = STATUS_ADDR;
      end
      S_WTX: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = 4'b0001;
        wbm_adr_o = TXDATA_ADDR;
        wbm_dat_o = {24'h0, hold_q};
      end
      S_RRX: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = RXDATA_ADDR;
      end
      default: ;
    endcase
  end

  always_comb begin
    poll_d = (state_q == S_IDLE && poll_q != POLL_LAST) ? poll_q + PW'(1) : '0;

    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (tx_valid && tx_ready) begin
      hold_d     = tx_data;
      hold_vld_d = 1'b1;
    end else if (state_q == S_WTX && ack) begin
      hold_vld_d = 1'b0;
    end

    rx_dat_d = rx_dat_q;
    rx_vld_d = rx_vld_q;
    if (state_q == S_RRX && ack) begin
      rx_dat_d = wbm_dat_i[7:0];
      rx_vld_d = 1'b1;
    end else if (rx_vld_q && rx_ready) begin
      rx_vld_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      poll_q     <= '0;
      hold_q     <= 8'h0;
      hold_vld_q <= 1'b0;
      rx_dat_q   <= 8'h0;
      rx_vld_q   <= 1'b0;
    end else begin
      poll_q     <= poll_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rx_dat_q   <= rx_dat_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge with a zero-wait Wishbone slave model that logs every acked transfer.
`timescale 1ns/1ps
module tb_uart_stream_bridge;

  localparam logic [31:0] A_STAT = 32'h3000_0008;
  localparam logic [31:0] A_TX   = 32'h3000_0004;
  localparam logic [31:0] A_RX   = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        err;
  logic        err_clr = 1'b0;

  uart_stream_bridge #(.POLL_DIV(4), .TIMEOUT_CYCLES(10)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .err(err), .err_clr(err_clr)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt++;

  // Slave model: acks on the second negedge of each cycle, so the DUT sees ack one clock after stb.
  logic        ack_en = 1'b1;
  logic [31:0] stat_word = 32'h2;
  logic [31:0] rx_word = 32'h0;
  int          scnt = 0;
  int          log_n = 0;
  logic [31:0] log_adr [512];
  logic [31:0] log_dat [512];
  logic [3:0]  log_sel [512];
  logic        log_we  [512];
  int          log_t   [512];

  always @(negedge wb_clk_i) begin
    if (wbm_ack_i) begin
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'h0;
      scnt = (wbm_cyc_o && wbm_stb_o) ? 1 : 0;
    end else if (wbm_cyc_o && wbm_stb_o) begin
      scnt++;
      if (ack_en && scnt >= 2) begin
        wbm_ack_i = 1'b1;
        if (!wbm_we_o) wbm_dat_i = (wbm_adr_o == A_STAT) ? stat_word : rx_word;
        if (log_n < 512) begin
          log_adr[log_n] = wbm_adr_o;
          log_dat[log_n] = wbm_dat_o;
          log_sel[log_n] = wbm_sel_o;
          log_we[log_n]  = wbm_we_o;
          log_t[log_n]   = cyc_cnt;
          log_n++;
        end
      end
    end else begin
      scnt = 0;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int base = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic wait_log(input int n, input string nm);
    int k;
    k = 0;
    while (log_n < n && k < 300) begin
      step();
      k++;
    end
    if (log_n < n) begin
      n_chk++;
      $display("FAIL %s: only %0d transfers logged, expected %0d", nm, log_n, n);
    end
  endtask

  task automatic do_reset();
    wb_rst_n_i = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    err_clr = 1'b0;
    ack_en = 1'b1;
    step();
    step();
    wb_rst_n_i = 1'b1;
    base = log_n;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  typedef struct {
    logic        push;
    logic [7:0]  txb;
    logic [31:0] stat;
    logic [31:0] rxw;
    int          kind;     // 0 none, 1 TXDATA write, 2 RXDATA read after the status poll
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic        exp_txr;
    logic        exp_rxv;
    logic [7:0]  exp_rx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int nw;
    int k;
    vecs[0] = '{1'b1, 8'hA5, 32'h0, 32'h0,         1, A_TX, 32'h0000_00A5, 4'b0001, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h5A, 32'h2, 32'h0,         1, A_TX, 32'h0000_005A, 4'b0001, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 32'h0, 32'h0000_003C, 2, A_RX, 32'h0,         4'hF,    1'b0, 1'b1, 1'b1, 8'h3C};
    vecs[3] = '{1'b0, 8'h00, 32'h2, 32'h0000_0077, 0, A_RX, 32'h0,         4'hF,    1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 8'hFF, 32'h1, 32'h1234_56C3, 2, A_RX, 32'h0,         4'hF,    1'b0, 1'b0, 1'b1, 8'hC3};
    vecs[5] = '{1'b1, 8'h00, 32'h3, 32'h0000_0011, 0, A_RX, 32'h0,         4'hF,    1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 32'hFFFF_FFFC, 32'hFFFF_FF81, 2, A_RX, 32'h0, 4'hF,    1'b0, 1'b1, 1'b1, 8'h81};

    // Reset values
    step();
    check("rst bus ctl", {28'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, 1'b0} | {24'h0, wbm_sel_o, 4'h0}, 32'h0);
    check("rst adr", wbm_adr_o, 32'h0);
    check("rst dat_o", wbm_dat_o, 32'h0);
    check("rst tx_ready", 32'(tx_ready), 32'h1);
    check("rst rx_valid", 32'(rx_valid), 32'h0);
    check("rst rx_data", 32'(rx_data), 32'h0);
    check("rst err", 32'(err), 32'h0);

    // One status poll per vector and the transfer it triggers
    for (int i = 0; i < 7; i++) begin
      stat_word = vecs[i].stat;
      rx_word = vecs[i].rxw;
      do_reset();
      if (vecs[i].push) push(vecs[i].txb);
      wait_log(base + 1, $sformatf("vec%0d status poll", i));
      for (int s = 0; s < 4; s++) step();
      check($sformatf("vec%0d transfer count", i), 32'(log_n - base), (vecs[i].kind != 0) ? 32'd2 : 32'd1);
      check($sformatf("vec%0d status adr", i), log_adr[base], A_STAT);
      if (vecs[i].kind != 0) begin
        check($sformatf("vec%0d adr", i), log_adr[base + 1], vecs[i].exp_adr);
        check($sformatf("vec%0d we/sel", i), {27'h0, log_we[base + 1], log_sel[base + 1]},
              {27'h0, vecs[i].exp_we, vecs[i].exp_sel});
      end
      if (vecs[i].kind == 1) check($sformatf("vec%0d dat_o", i), log_dat[base + 1], vecs[i].exp_dat);
      check($sformatf("vec%0d tx_ready", i), 32'(tx_ready), 32'(vecs[i].exp_txr));
      check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_rxv));
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
    end

    // TX timing: tx_ready returns the cycle after ack; back-to-back byte period is POLL_DIV+4
    stat_word = 32'h0;
    do_reset();
    push(8'hA5);
    wait_log(base + 2, "txt first write");
    check("txt tx_ready at ack", 32'(tx_ready), 32'h0);
    step();
    check("txt tx_ready after ack", 32'(tx_ready), 32'h1);
    check("txt cyc after ack", 32'(wbm_cyc_o), 32'h0);
    push(8'h5A);
    wait_log(base + 4, "txt second write");
    check("txt byte period", 32'(log_t[base + 3] - log_t[base + 1]), 32'd8);
    check("txt second dat", log_dat[base + 3], 32'h0000_005A);

    // TX backpressure: three full polls, then one write
    stat_word = 32'h1;
    do_reset();
    push(8'h77);
    wait_log(base + 3, "bp full polls");
    check("bp tx_ready while full", 32'(tx_ready), 32'h0);
    stat_word = 32'h0;
    wait_log(base + 5, "bp write");
    nw = 0;
    for (int i = 0; i < 4; i++) if (log_we[base + i]) nw++;
    check("bp writes during full", 32'(nw), 32'h0);
    check("bp write adr", log_adr[base + 4], A_TX);
    check("bp write dat", log_dat[base + 4], 32'h0000_0077);
    check("bp tx_ready at ack", 32'(tx_ready), 32'h0);
    step();
    check("bp tx_ready after", 32'(tx_ready), 32'h1);

    // RX hold, and an rx_ready handshake coinciding with a status ack
    stat_word = 32'h0;
    rx_word = 32'h0000_003C;
    do_reset();
    wait_log(base + 2, "rx first read");
    check("rx read adr", log_adr[base + 1], A_RX);
    check("rx valid at ack", 32'(rx_valid), 32'h0);
    step();
    check("rx valid after ack", 32'(rx_valid), 32'h1);
    check("rx data after ack", 32'(rx_data), 32'h3C);
    rx_word = 32'h0000_0055;
    wait_log(base + 4, "rx held polls");
    check("rx no read while held a", log_adr[base + 2], A_STAT);
    check("rx no read while held b", log_adr[base + 3], A_STAT);
    check("rx data held", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("rx valid cleared", 32'(rx_valid), 32'h0);
    wait_log(base + 6, "rx second read");
    check("rx same-cycle ack poll", log_adr[base + 4], A_STAT);
    check("rx second read adr", log_adr[base + 5], A_RX);
    step();
    check("rx second data", 32'(rx_data), 32'h55);

    // Priority: TX before RX from the same status word
    stat_word = 32'h0;
    rx_word = 32'h0000_0042;
    do_reset();
    push(8'h99);
    wait_log(base + 4, "prio transfers");
    check("prio first adr", log_adr[base + 1], A_TX);
    check("prio first dat", log_dat[base + 1], 32'h0000_0099);
    check("prio repoll adr", log_adr[base + 2], A_STAT);
    check("prio read adr", log_adr[base + 3], A_RX);
    step();
    check("prio rx data", 32'(rx_data), 32'h42);

    // Reset in the middle of a TXDATA write
    stat_word = 32'h0;
    do_reset();
    push(8'h11);
    wait_log(base + 1, "mid status");
    step();
    check("mid in write", {29'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h7);
    wb_rst_n_i = 1'b0;
    #1;
    check("mid async drop", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    stat_word = 32'h2;
    step();
    wb_rst_n_i = 1'b1;
    base = log_n;
    step();
    check("mid tx_ready", 32'(tx_ready), 32'h1);
    check("mid rx_valid", 32'(rx_valid), 32'h0);
    check("mid err", 32'(err), 32'h0);
    wait_log(base + 2, "mid polls");
    check("mid byte dropped", log_adr[base + 1], A_STAT);

`ifdef UART_BRIDGE_TIMEOUT_EN
    // Ack timeout aborts the cycle and latches err
    stat_word = 32'h2;
    do_reset();
    ack_en = 1'b0;
    k = 0;
    while (!wbm_stb_o && k < 50) begin
      step();
      k++;
    end
    check("to stb rose", 32'(wbm_stb_o), 32'h1);
    k = 0;
    while (wbm_cyc_o && k < 40) begin
      step();
      k++;
    end
    check("to cycles to drop", 32'(k), 32'd11);
    check("to err set", 32'(err), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to err cleared", 32'(err), 32'h0);
    ack_en = 1'b1;
    k = log_n;
    wait_log(k + 1, "to poll resumes");
    check("to resumed adr", log_adr[k], A_STAT);
    check("to err stays clear", 32'(err), 32'h0);
`else
    // Without the timeout the bridge waits for ack indefinitely
    stat_word = 32'h2;
    do_reset();
    ack_en = 1'b0;
    for (int s = 0; s < 30; s++) step();
    check("nto still waiting", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h3);
    check("nto err low", 32'(err), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    ack_en = 1'b1;
    wait_log(base + 1, "nto late ack");
    check("nto late ack adr", log_adr[base], A_STAT);
    check("nto err after", 32'(err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_stream_bridge.md
# uart_stream_bridge

Wishbone master sitting directly upstream of the UART macro wrapper's Wishbone slave port. It converts a byte-wide valid/ready TX stream into polled writes of the UART TX data register, and drains the UART RX data register into a byte-wide valid/ready RX stream. Fabric logic can therefore use the UART without a CPU. One Wishbone transaction is in flight at a time, under a single-FSM controller.

## Interface
Parameters:
- STATUS_ADDR, 32'h3000_0008: UART status register address.
- TXDATA_ADDR, 32'h3000_0004: UART TX data register address.
- RXDATA_ADDR, 32'h3000_0000: UART RX data register address.
- TX_FULL_BIT, 0: status bit index; 1 means TX FIFO full.
- RX_EMPTY_BIT, 1: status bit index; 1 means RX FIFO empty.
- POLL_DIV, 16: idle cycles between status polls (≥1).
- TIMEOUT_CYCLES, 255: ack wait limit (used only with UART_BRIDGE_TIMEOUT_EN).

Ports (one clock; reset is asynchronous and active-low):
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_n_i  in  1  asynchronous active-low reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  bridge accepts byte
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  consumer accepts byte
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave ack
- err  out  1  sticky ack-timeout flag
- err_clr  in  1  clears err

## Operation
- TX holding register: 1 entry. tx_ready = holding empty. A byte is captured on tx_valid&&tx_ready. The entry is cleared only on the ack of its TXDATA write.
- RX output register: 1 entry. Loaded on the RXDATA read ack, which sets rx_valid. rx_valid stays high, with rx_data stable, until rx_valid&&rx_ready.
- FSM states:
  - IDLE: poll counter counts up; on reaching POLL_DIV-1 → STAT. The counter resets to 0 on entering IDLE.
  - STAT: read STATUS_ADDR; on ack, sample the status word. If holding full and TX_FULL_BIT==0 → WTX. Else if RX_EMPTY_BIT==0 and !rx_valid → RRX. Else → IDLE. TX has priority over RX.
  - WTX: write {24'h0, holding} to TXDATA_ADDR with sel=4'b0001; on ack clear holding → IDLE.
  - RRX: read RXDATA_ADDR with sel=4'hF; on ack rx_data ← wbm_dat_i[7:0], rx_valid ← 1 → IDLE.
- Wishbone handshake:
  - cyc and stb rise together on the state-entry cycle and are held until the ack cycle; both deassert the cycle after ack.
  - adr, we, sel and dat_o are stable for the whole cycle; we=1 only in WTX.
  - An ack outside an active cycle is ignored.
- Simultaneous events:
  - A tx_valid accept in the same cycle as the WTX ack is impossible, since tx_ready=0 while the holding register is full.
  - An rx_ready handshake in the same cycle as a STAT ack does not make RRX eligible; the decision uses registered rx_valid.
- err_clr has priority over a same-cycle timeout set.

## Timing
- Reset values:
  - tx_ready=1, rx_valid=0, rx_data=0, err=0.
  - cyc, stb and we = 0; sel, adr and dat_o = 0.
  - FSM in IDLE, poll counter = 0.
- Reset mid-transaction drops cyc/stb asynchronously; the holding byte is lost.
- With a zero-wait slave (ack one cycle after stb):
  - STAT occupies 2 cycles and WTX or RRX occupies 2 cycles.
  - Minimum byte period is POLL_DIV + 4 cycles.
- tx_valid-to-first-stb latency is ≤ POLL_DIV + 1 cycles.
- RX byte appears on rx_data 1 cycle after the RRX ack.

## Configuration
- Macro: UART_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter runs while cyc=1.
  - If it reaches TIMEOUT_CYCLES without ack: cyc/stb drop next cycle, err sets (sticky until err_clr), FSM → IDLE.
  - The TX holding byte is retained for retry, and the RX register is unchanged.
- Undefined: the bridge waits for ack indefinitely, err is tied 0, and err_clr is ignored.

## Test plan
- Reset: assert wb_rst_n_i=0 mid-WTX → cyc/stb=0 immediately; tx_ready=1, rx_valid=0, err=0 after release.
- TX path: POLL_DIV=4, push 8'hA5, status returns 0 → one write to TXDATA_ADDR with dat_o=32'h0000_00A5 and sel=4'b0001; tx_ready returns 1 the cycle after ack.
- TX backpressure: status TX_FULL_BIT=1 for 3 polls, then 0 → no write during the 3 full polls, exactly one write after; tx_ready stays 0 throughout.
- RX path: status RX_EMPTY_BIT=0, RXDATA returns 32'h0000_003C, rx_ready=0 → rx_valid=1, rx_data=8'h3C held. A further non-empty status issues no RRX until rx_ready is pulsed.
- Priority: holding full and RX non-empty in the same status word → WTX issued first, RRX on the next poll.
- Timeout (macro defined, TIMEOUT_CYCLES=10): slave never acks STAT → cyc drops 11 cycles after stb and err=1. An err_clr pulse gives err=0, and polling resumes.
